// File: rtl/system_test_pkg.sv
// Shared definitions for the system_test multicycle CPU: opcodes, FSM states,
// ALU / writeback-source codes and build defaults.
package system_test_pkg;

  localparam logic [3:0] OP_ADDI = 4'b0001;
  localparam logic [3:0] OP_LUI  = 4'b0011;
  localparam logic [3:0] OP_CPI  = 4'b0111;
  localparam logic [3:0] OP_ORI  = 4'b1101;

  typedef enum logic [8:0] {
    S_FETCH  = 9'b000000001,
    S_DECODE = 9'b000000010,
    S_EXEC   = 9'b000000100,
    S_WB     = 9'b000001000
  } state_e;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_OR    = 3'd1;
  localparam logic [2:0] ALU_PASSB = 3'd2;

  localparam logic [2:0] RWSRC_ALU = 3'd0;
  localparam logic [2:0] RWSRC_LUI = 3'd1;

  localparam logic [15:0] SP_RESET_DEFAULT  = 16'h03FF;
  localparam int unsigned MEM_WORDS_DEFAULT = 1024;

  function automatic logic is_imm_op(input logic [3:0] op);
    return (op == OP_ADDI) || (op == OP_ORI) || (op == OP_LUI) || (op == OP_CPI);
  endfunction

endpackage

// File: rtl/system_test_if.sv
// Debug access bus: lets the bench read/write memory and registers while the
// CPU is stalled.
interface system_test_if;
  logic        memoryoperation;
  logic        registeroperation;
  logic        memorywrite;
  logic        registerwrite;
  logic [15:0] memwritedata;
  logic [15:0] memaddress;
  logic [15:0] regwritedata;
  logic [3:0]  registeraddress;
  logic [15:0] RD;
  logic [15:0] MD;

  modport master (
    output memoryoperation, registeroperation, memorywrite, registerwrite,
           memwritedata, memaddress, regwritedata, registeraddress,
    input  RD, MD
  );

  modport slave (
    input  memoryoperation, registeroperation, memorywrite, registerwrite,
           memwritedata, memaddress, regwritedata, registeraddress,
    output RD, MD
  );
endinterface

// File: rtl/system_test_cpu_regfile.sv
// 16x16 register file, one write port and a registered read port; the debug
// port takes over both address and write path when selected.
module cpu_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic        dbg_sel,
  input  logic        dbg_we,
  input  logic [3:0]  dbg_addr,
  input  logic [15:0] dbg_wdata,
  input  logic        cpu_we,
  input  logic [3:0]  cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] rd_data
);

  logic [15:0] regs [16];
  logic        we;
  logic [3:0]  addr;
  logic [15:0] wdata;

  always_comb begin
    addr  = dbg_sel ? dbg_addr  : cpu_addr;
    wdata = dbg_sel ? dbg_wdata : cpu_wdata;
    we    = ~reset & (dbg_sel ? dbg_we : cpu_we);
  end

  always_ff @(posedge clk) begin
    if (we) regs[addr] <= wdata;
  end

  // Read returns the value being written on the same edge.
  always_ff @(posedge clk) begin
    rd_data <= we ? wdata : regs[addr];
  end

endmodule

// File: rtl/system_test.sv
// 16-bit multicycle CPU executing addi/ori/lui/cpi with a debug access port
// and exposed datapath/control signals.
module system_test
  import system_test_pkg::*;
#(
  parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT,
  parameter logic [15:0] SP_RESET  = SP_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        test,
  input  logic [15:0] resetpc,
  system_test_if.slave dbg,
  output logic [15:0] PC,
  output logic [15:0] SP,
  output logic [9:1]  state,
  output logic        FU,
  output logic        RW,
  output logic        PCW,
  output logic        SPW,
  output logic        MW,
  output logic        IW,
  output logic        MSrc,
  output logic        LM,
  output logic        SrcB,
  output logic        Jump,
  output logic        SPIorD,
  output logic        IorD,
  output logic        Perform,
  output logic        LMC,
  output logic [2:0]  ALUOp,
  output logic [2:0]  RWSrc,
  output logic [3:0]  Op,
  output logic [15:0] x,
  output logic [3:0]  y,
  output logic        z,
  output logic [15:0] display
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  state_e      st_q, st_d;
  logic [15:0] ir;
  logic [15:0] alu_q;
  logic [15:0] a_val;
  logic [15:0] b_val;
  logic [7:0]  imm8;
  logic [15:0] mem_addr;
  logic [AW-1:0] mem_idx;
  logic        mem_we;
  logic [15:0] mem [MEM_WORDS];

  assign Perform = test & ~dbg.memoryoperation & ~dbg.registeroperation;
  assign SPW     = 1'b0;
  assign MW      = 1'b0;
  assign Jump    = 1'b0;
  assign SPIorD  = 1'b0;
  assign MSrc    = 1'b0;
  assign LM      = 1'b0;
  assign LMC     = 1'b0;
  assign IorD    = 1'b0;

  assign state   = st_q;
  assign Op      = ir[15:12];
  assign y       = ir[11:8];
  assign imm8    = ir[7:0];
  assign display = ir;

  // Memory: debug address overrides the PC; only the debug port writes.
  assign mem_addr = dbg.memoryoperation ? dbg.memaddress : PC;
  assign mem_idx  = AW'(mem_addr % 16'(MEM_WORDS));
  assign mem_we   = ~reset & dbg.memoryoperation & dbg.memorywrite;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= dbg.memwritedata;
  end

  always_ff @(posedge clk) begin
    dbg.MD <= mem_we ? dbg.memwritedata : mem[mem_idx];
  end

  cpu_regfile u_regfile (
    .clk       (clk),
    .reset     (reset),
    .dbg_sel   (dbg.registeroperation),
    .dbg_we    (dbg.registerwrite),
    .dbg_addr  (dbg.registeraddress),
    .dbg_wdata (dbg.regwritedata),
    .cpu_we    (RW),
    .cpu_addr  (ir[11:8]),
    .cpu_wdata (alu_q),
    .rd_data   (dbg.RD)
  );

  // The registered read port addresses rd continuously, so RD holds reg[rd]
  // from the Decode edge onward and serves as the A operand.
  assign a_val = dbg.RD;

  always_comb begin
    ALUOp = ALU_ADD;
    RWSrc = RWSRC_ALU;
    b_val = {{8{imm8[7]}}, imm8};
    case (Op)
      OP_ADDI: ALUOp = ALU_ADD;
      OP_ORI: begin
        ALUOp = ALU_OR;
        b_val = {8'h00, imm8};
      end
      OP_LUI: begin
        ALUOp = ALU_PASSB;
        RWSrc = RWSRC_LUI;
        b_val = {imm8, 8'h00};
      end
      OP_CPI: ALUOp = ALU_PASSB;
      default: ;
    endcase
  end

  always_comb begin
    case (ALUOp)
      ALU_ADD:   x = a_val + b_val;
      ALU_OR:    x = a_val | b_val;
      ALU_PASSB: x = b_val;
      default:   x = '0;
    endcase
  end

  always_comb begin
    st_d = st_q;
    FU   = 1'b0;
    RW   = 1'b0;
    PCW  = 1'b0;
    IW   = 1'b0;
    SrcB = 1'b0;
    if (Perform) begin
      case (st_q)
        S_FETCH: begin
          IW   = 1'b1;
          PCW  = 1'b1;
          st_d = S_DECODE;
        end
        S_DECODE: begin
          SrcB = 1'b1;
          st_d = is_imm_op(Op) ? S_EXEC : S_FETCH;
        end
        S_EXEC: begin
          FU   = 1'b1;
          SrcB = 1'b1;
          st_d = S_WB;
        end
        S_WB: begin
          RW   = 1'b1;
          st_d = S_FETCH;
        end
        default: st_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q  <= S_FETCH;
      PC    <= resetpc;
      SP    <= SP_RESET;
      ir    <= '0;
      z     <= 1'b0;
      alu_q <= '0;
    end else begin
      st_q <= st_d;
      if (PCW) PC <= PC + 16'd1;
      if (IW)  ir <= mem[mem_idx];
      if (FU) begin
        alu_q <= x;
        z     <= (x == 16'h0000);
      end
    end
  end

endmodule

// File: tb/tb_system_test.sv
// Directed bench for system_test: debug loads, single-instruction runs with
// hand-computed results, stall/priority and mid-instruction reset.
module tb_system_test;

  logic        clk = 1'b0;
  logic        reset;
  logic        test;
  logic [15:0] resetpc;
  logic [15:0] PC, SP, x, display;
  logic [9:1]  state;
  logic        FU, RW, PCW, SPW, MW, IW, MSrc, LM, SrcB, Jump, SPIorD, IorD, Perform, LMC, z;
  logic [2:0]  ALUOp, RWSrc;
  logic [3:0]  Op, y;

  int unsigned total = 0;
  int unsigned bad   = 0;

  system_test_if dbg ();

  system_test #(.MEM_WORDS(1024), .SP_RESET(16'h03FF)) dut (
    .clk(clk), .reset(reset), .test(test), .resetpc(resetpc), .dbg(dbg),
    .PC(PC), .SP(SP), .state(state), .FU(FU), .RW(RW), .PCW(PCW), .SPW(SPW),
    .MW(MW), .IW(IW), .MSrc(MSrc), .LM(LM), .SrcB(SrcB), .Jump(Jump),
    .SPIorD(SPIorD), .IorD(IorD), .Perform(Perform), .LMC(LMC),
    .ALUOp(ALUOp), .RWSrc(RWSrc), .Op(Op), .x(x), .y(y), .z(z), .display(display)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic mem_wr(input logic [15:0] a, input logic [15:0] d);
    dbg.memoryoperation = 1'b1; dbg.memorywrite = 1'b1;
    dbg.memaddress = a; dbg.memwritedata = d;
    @(negedge clk);
    dbg.memoryoperation = 1'b0; dbg.memorywrite = 1'b0;
  endtask

  task automatic mem_rd(input logic [15:0] a, output logic [15:0] d);
    dbg.memoryoperation = 1'b1; dbg.memaddress = a;
    @(negedge clk);
    d = dbg.MD;
    dbg.memoryoperation = 1'b0;
  endtask

  task automatic reg_wr(input logic [3:0] a, input logic [15:0] d);
    dbg.registeroperation = 1'b1; dbg.registerwrite = 1'b1;
    dbg.registeraddress = a; dbg.regwritedata = d;
    @(negedge clk);
    dbg.registeroperation = 1'b0; dbg.registerwrite = 1'b0;
  endtask

  task automatic reg_rd(input logic [3:0] a, output logic [15:0] d);
    dbg.registeroperation = 1'b1; dbg.registeraddress = a;
    @(negedge clk);
    d = dbg.RD;
    dbg.registeroperation = 1'b0;
  endtask

  task automatic do_reset(input logic [15:0] pc);
    reset = 1'b1; resetpc = pc;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run(input int n);
    test = 1'b1;
    repeat (n) @(negedge clk);
    test = 1'b0;
  endtask

  logic [15:0] v;

  initial begin
    reset = 1'b1; test = 1'b0; resetpc = '0;
    dbg.memoryoperation = 1'b0; dbg.registeroperation = 1'b0;
    dbg.memorywrite = 1'b0; dbg.registerwrite = 1'b0;
    dbg.memwritedata = '0; dbg.memaddress = '0;
    dbg.regwritedata = '0; dbg.registeraddress = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // addi: 11 + 5
    mem_wr(16'd3, 16'h1005);
    reg_wr(4'd0, 16'd11);
    do_reset(16'd3);
    chk("rst_state", 16'(state), 16'h0001);
    chk("rst_pc", PC, 16'd3);
    chk("rst_sp", SP, 16'h03FF);
    chk("rst_ir", display, 16'h0000);
    chk("rst_z", 16'(z), 16'h0000);
    run(1);
    chk("fetch_md", dbg.MD, 16'h1005);
    chk("fetch_pc", PC, 16'd4);
    chk("fetch_state", 16'(state), 16'h0002);
    run(3);
    chk("addi_state", 16'(state), 16'h0001);
    reg_rd(4'd0, v);
    chk("addi_r0", v, 16'd16);

    // addi wrap: 7FFF + 1
    mem_wr(16'd4, 16'h1101);
    reg_wr(4'd1, 16'h7FFF);
    do_reset(16'd4);
    run(4);
    reg_rd(4'd1, v);
    chk("addi_wrap", v, 16'h8000);
    chk("addi_wrap_z", 16'(z), 16'h0000);

    // ori pair, second continues from PC=4
    mem_wr(16'd3, 16'hD005);
    mem_wr(16'd4, 16'hD101);
    reg_wr(4'd0, 16'd8);
    reg_wr(4'd1, 16'h000E);
    do_reset(16'd3);
    run(4);
    reg_rd(4'd0, v);
    chk("ori_r0", v, 16'h000D);
    run(4);
    reg_rd(4'd1, v);
    chk("ori_r1", v, 16'h000F);
    chk("ori_pc", PC, 16'd5);

    // lui
    mem_wr(16'd5, 16'h30FF);
    run(4);
    reg_rd(4'd0, v);
    chk("lui_ff", v, 16'hFF00);
    mem_wr(16'd5, 16'h30AA);
    do_reset(16'd5);
    run(4);
    reg_rd(4'd0, v);
    chk("lui_aa", v, 16'hAA00);

    // cpi
    mem_wr(16'd6, 16'h71FF);
    do_reset(16'd6);
    run(4);
    reg_rd(4'd1, v);
    chk("cpi_ff", v, 16'hFFFF);
    chk("cpi_ff_z", 16'(z), 16'h0000);
    mem_wr(16'd6, 16'h7100);
    do_reset(16'd6);
    run(4);
    reg_rd(4'd1, v);
    chk("cpi_00", v, 16'h0000);
    chk("cpi_00_z", 16'(z), 16'h0001);

    // unknown opcode: two cycles, no write
    mem_wr(16'd7, 16'h0000);
    do_reset(16'd7);
    run(2);
    chk("nop_state", 16'(state), 16'h0001);
    chk("nop_pc", PC, 16'd8);
    reg_rd(4'd0, v);
    chk("nop_r0", v, 16'hAA00);

    // address wraps modulo memory depth
    mem_wr(16'h0407, 16'h2222);
    mem_rd(16'h0007, v);
    chk("mem_modulo", v, 16'h2222);

    // stall in Decode for 20 cycles, then resume
    reg_wr(4'd0, 16'd8);
    do_reset(16'd3);
    run(1);
    repeat (20) @(negedge clk);
    chk("stall_state", 16'(state), 16'h0002);
    chk("stall_pc", PC, 16'd4);
    reg_rd(4'd0, v);
    chk("stall_r0", v, 16'd8);
    run(3);
    chk("resume_state", 16'(state), 16'h0001);
    reg_rd(4'd0, v);
    chk("resume_r0", v, 16'h000D);

    // debug op beats test=1
    test = 1'b1; dbg.memoryoperation = 1'b1; dbg.memaddress = 16'd3;
    repeat (2) @(negedge clk);
    chk("prio_md", dbg.MD, 16'hD005);
    chk("prio_state", 16'(state), 16'h0001);
    chk("prio_pc", PC, 16'd4);
    chk("prio_perform", 16'(Perform), 16'h0000);
    dbg.memoryoperation = 1'b0; test = 1'b0;

    // reset in Execute aborts the instruction
    reg_wr(4'd0, 16'd8);
    do_reset(16'd3);
    run(2);
    chk("s3_state", 16'(state), 16'h0004);
    test = 1'b1; reset = 1'b1; resetpc = 16'd9;
    @(negedge clk);
    reset = 1'b0; test = 1'b0;
    chk("s3rst_state", 16'(state), 16'h0001);
    chk("s3rst_pc", PC, 16'd9);
    reg_rd(4'd0, v);
    chk("s3rst_r0", v, 16'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/system_test.md
Name: system_test

Overview:
- Self-contained 16-bit multicycle CPU: PC, SP, 16x16 register file, instruction register, word-addressed unified memory, one-hot control FSM.
- Debug port gives the test bench direct read/write access to memory and registers while the CPU is stalled.
- Debug outputs expose datapath and control signals.
- This build executes the immediate-class instructions addi, ori, lui and cpi.

Parameters:
- MEM_WORDS, 1024: memory depth in 16-bit words; addresses are taken modulo MEM_WORDS.
- SP_RESET, 16'h03FF: SP value loaded on reset.

Ports:
- clk in 1: single clock, rising edge active.
- reset in 1: synchronous, active-high.
- test in 1: CPU run enable.
- memoryoperation in 1: debug memory access select.
- registeroperation in 1: debug register access select.
- memorywrite in 1: debug memory write enable.
- registerwrite in 1: debug register write enable.
- memwritedata in 16: debug memory write data.
- memaddress in 16: debug memory address.
- resetpc in 16: PC value loaded on reset.
- regwritedata in 16: debug register write data.
- registeraddress in 4: debug register index.
- RD out 16: registered register-file read data.
- MD out 16: registered memory read data.
- PC out 16, SP out 16: architectural registers.
- state out 9 ([9:1]): one-hot FSM state.
- Single-bit control outputs: FU, RW, PCW, SPW, MW, IW, MSrc, LM, SrcB, Jump, SPIorD, IorD, Perform, LMC.
- ALUOp out 3, RWSrc out 3, Op out 4 (IR[15:12]).
- x out 16 (ALU result), y out 4 (IR[11:8]), z out 1 (zero flag), display out 16 (IR).

Behaviour:
- Priority per cycle: reset > debug op (memoryoperation or registeroperation) > CPU run (test=1).
- Perform = test & ~memoryoperation & ~registeroperation.
- When Perform=0, the FSM, PC, IR and flags hold, and the CPU issues no writes.
- Reset (any test value):
  - PC<=resetpc, SP<=SP_RESET, state<=9'b000000001 (Fetch), IR<=0, z<=0.
  - Register file and memory are not cleared.
- Debug memory access (memoryoperation=1):
  - Memory address = memaddress.
  - memorywrite=1 writes memwritedata on the edge.
  - MD <= mem[address] on every edge; a read issued after a write returns the new data.
- Debug register access (registeroperation=1):
  - Index = registeraddress; registerwrite=1 writes regwritedata.
  - RD <= reg[index] each edge, reading after the write.
- Instruction format: [15:12] opcode, [11:8] register rd, [7:0] imm8.
- FSM, one-hot, 4 cycles per instruction:
  - S1 Fetch (state=1): IorD=0, address=PC; MD/IR <= mem[PC]; PC<=PC+1. IW=PCW=1.
  - S2 Decode (state=2): A <= reg[rd]; SrcB=1.
  - S3 Execute (state=4): ALU result latched; FU=1; z <= (result==0).
  - S4 Writeback (state=8): RW=1; reg[rd] <= latched result; next state S1.
  - state bits 5-9 are reserved and never set.
- Instruction results (16-bit, wrap-around, no overflow trap):
  - 0001 addi: rd = rd + sext(imm8). ALUOp=0.
  - 1101 ori: rd = rd | zext(imm8). ALUOp=1.
  - 0011 lui: rd = {imm8, 8'h00}. ALUOp=2 (pass B), RWSrc=1.
  - 0111 cpi: rd = sext(imm8). ALUOp=2, RWSrc=0.
- Any other opcode is a NOP: S2 returns directly to S1 with no writes.
- Constant in this build: SPW=MW=Jump=SPIorD=MSrc=LM=LMC=0.
- Reset asserted mid-instruction aborts it; no write completes on that edge.

Decomposition:
- Shared package: opcode constants, one-hot state encodings, ALUOp and RWSrc codes, SP_RESET default.
- Natural sub-module: cpu_regfile (16x16, one write port, registered read port, debug mux at its inputs).
- Memory, ALU and FSM stay inline.

Test Plan:
- Write mem[3]=16'h1005 and reg0=11 via debug, reset with resetpc=3, run until Fetch is re-entered -> reg0=16; at the cycle after the first Fetch, MD=16'h1005 and PC=4.
- mem[4]=16'h1101, reg1=16'h7FFF, run from 4 -> reg1=16'h8000 (wrap, no trap).
- mem[3]=16'hD005 with reg0=8 -> reg0=16'h000D; mem[4]=16'hD101 with reg1=16'h000E -> reg1=16'h000F.
- mem[5]=16'h30FF -> reg0=16'hFF00; mem[5]=16'h30AA -> reg0=16'hAA00.
- mem[6]=16'h71FF -> reg1=16'hFFFF; mem[6]=16'h7100 -> reg1=16'h0000, z=1.
- Stall and priority:
  - Hold test=0 for 20 cycles: state, PC and registers unchanged.
  - Assert memoryoperation with test=1: CPU stalls, debug read of mem[3] returns its contents on MD two edges later.
  - Reset during S3: next state=1, PC=resetpc.
